i2s_rx_frame_sync: RTL and testbench

// Pairs the per-channel words from the I2S receiver (sck domain) into stereo frames.

---
 rtl/i2s_rx_frame_sync_pkg.sv | 29 ++
 rtl/i2s_rx_frame_sync_toggle_sync.sv | 33 +++
 rtl/i2s_rx_frame_sync.sv | 187 ++++++++++++++++++
 tb/tb_i2s_rx_frame_sync.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_rx_frame_sync_pkg.sv
// Shared types and constants for the I2S receive frame synchroniser.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`timescale 1ns/100ps
package i2s_rx_frame_sync_pkg;

  // Sample width that matches the upstream receiver
  localparam int BITS_PRECISION_DEFAULT = 24;
  localparam int SYNC_STAGES_DEFAULT    = 2;
  localparam logic [7:0] CNT_MAX        = 8'hFF;

  typedef logic [BITS_PRECISION_DEFAULT-1:0] sample_t;

  typedef struct packed {
    sample_t l;
    sample_t r;
  } frame_t;

  typedef enum logic {
    WAIT_L = 1'b0,
    HAVE_L = 1'b1
  } pair_state_t;

  // Saturating increment for the 8-bit status counters
  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == CNT_MAX) ? c : c + 8'd1;
  endfunction

endpackage

// File: rtl/i2s_rx_frame_sync_toggle_sync.sv
// Carries a toggle signal into clk_i through SYNC_STAGES flops; emits level and edge pulse.
// Latency: lvl_o follows tgl_i after SYNC_STAGES edges; pulse_o is high for the cycle after.
// Backpressure: none; every toggle of tgl_i yields exactly one pulse_o cycle.
// Ports: clk_i/rst_i destination clock and async active-high reset, tgl_i source toggle,
//        lvl_o synchronised level, pulse_o one-cycle edge indication.
`timescale 1ns/100ps
module i2s_rx_frame_sync_toggle_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tgl_i,
  output logic lvl_o,
  output logic pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tgl_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign lvl_o   = sync_q[SYNC_STAGES-1];
  assign pulse_o = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/i2s_rx_frame_sync.sv
// Pairs L/R words from the sck domain into stereo frames and hands them to clk via toggle req/ack.
// Latency: out_valid rises SYNC_STAGES+1 clk edges after req toggles (idle output).
// Backpressure: one frame in out regs plus one in hold regs; further frames dropped and counted.
// Ports: clk/sck clocks, rst async active-high for both domains; in_data/in_lrn/in_en word strobe
//        (sck); out_left/out_right/out_valid/out_ready frame handshake (clk); ovr_cnt/orph_cnt
//        saturating status counters cleared by cnt_clr (clk).
`timescale 1ns/100ps
module i2s_rx_frame_sync #(
  parameter int BITS_PRECISION = i2s_rx_frame_sync_pkg::BITS_PRECISION_DEFAULT,
  parameter int SYNC_STAGES    = i2s_rx_frame_sync_pkg::SYNC_STAGES_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sck,
  input  logic [BITS_PRECISION-1:0] in_data,
  input  logic                      in_lrn,
  input  logic                      in_en,
  output logic [BITS_PRECISION-1:0] out_left,
  output logic [BITS_PRECISION-1:0] out_right,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                ovr_cnt,
  output logic [7:0]                orph_cnt,
  input  logic                      cnt_clr
);
  import i2s_rx_frame_sync_pkg::*;

  // Reset: asserted immediately, released synchronously in each domain
  logic [1:0] rst_clk_q, rst_sck_q;
  logic       rst_clk, rst_sck;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_clk_q <= 2'b11;
    else     rst_clk_q <= {rst_clk_q[0], 1'b0};
  end

  always_ff @(posedge sck or posedge rst) begin
    if (rst) rst_sck_q <= 2'b11;
    else     rst_sck_q <= {rst_sck_q[0], 1'b0};
  end

  assign rst_clk = rst_clk_q[1];
  assign rst_sck = rst_sck_q[1];

  // ---------------- sck domain ----------------
  pair_state_t               state_q, state_d;
  logic [BITS_PRECISION-1:0] left_q, left_d;
  logic [BITS_PRECISION-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic                      req_q, req_d, ovr_q, ovr_d, orph_q, orph_d;
  logic                      ack_lvl, ack_pulse;

  always_comb begin
    state_d  = state_q;
    left_d   = left_q;
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    req_d    = req_q;
    ovr_d    = ovr_q;
    orph_d   = orph_q;
    if (in_en) begin
      case (state_q)
        WAIT_L: begin
          if (in_lrn) begin
            left_d  = in_data;
            state_d = HAVE_L;
          end else begin
            orph_d = ~orph_q;
          end
        end
        HAVE_L: begin
          if (in_lrn) begin
            left_d = in_data;
            orph_d = ~orph_q;
          end else begin
            state_d = WAIT_L;
            // Hold regs are only written while the clk side has acknowledged them
            if (req_q == ack_lvl) begin
              hold_l_d = left_q;
              hold_r_d = in_data;
              req_d    = ~req_q;
            end else begin
              ovr_d = ~ovr_q;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge sck or posedge rst_sck) begin
    if (rst_sck) begin
      state_q  <= WAIT_L;
      left_q   <= '0;
      hold_l_q <= '0;
      hold_r_q <= '0;
      req_q    <= 1'b0;
      ovr_q    <= 1'b0;
      orph_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      left_q   <= left_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      req_q    <= req_d;
      ovr_q    <= ovr_d;
      orph_q   <= orph_d;
    end
  end

  // ---------------- synchronisers ----------------
  logic req_lvl, req_pulse, ovr_lvl, ovr_pulse, orph_lvl, orph_pulse;
  logic ack_q, ack_d;

  i2s_rx_frame_sync_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
    .clk_i(clk), .rst_i(rst_clk), .tgl_i(req_q), .lvl_o(req_lvl), .pulse_o(req_pulse));
  i2s_rx_frame_sync_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk_i(sck), .rst_i(rst_sck), .tgl_i(ack_q), .lvl_o(ack_lvl), .pulse_o(ack_pulse));
  i2s_rx_frame_sync_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ovr_sync (
    .clk_i(clk), .rst_i(rst_clk), .tgl_i(ovr_q), .lvl_o(ovr_lvl), .pulse_o(ovr_pulse));
  i2s_rx_frame_sync_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_orph_sync (
    .clk_i(clk), .rst_i(rst_clk), .tgl_i(orph_q), .lvl_o(orph_lvl), .pulse_o(orph_pulse));

  logic unused_sync_outs;
  assign unused_sync_outs = ^{req_lvl, ack_pulse, ovr_lvl, orph_lvl};

  // ---------------- clk domain ----------------
  logic [BITS_PRECISION-1:0] out_left_q, out_left_d, out_right_q, out_right_d;
  logic                      out_valid_q, out_valid_d, pend_q, pend_d;
  logic [7:0]                ovr_cnt_q, ovr_cnt_d, orph_cnt_q, orph_cnt_d;
  logic                      req_pend, capture;

  // The edge pulse counts as pending in its own cycle so capture is not delayed by a flop
  assign req_pend = pend_q | req_pulse;
  assign capture  = req_pend & (~out_valid_q | out_ready);

  always_comb begin
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    out_valid_d = out_valid_q;
    ack_d       = ack_q;
    pend_d      = req_pend & ~capture;
    ovr_cnt_d   = ovr_cnt_q;
    orph_cnt_d  = orph_cnt_q;
    if (capture) begin
      out_left_d  = hold_l_q;
      out_right_d = hold_r_q;
      out_valid_d = 1'b1;
      ack_d       = ~ack_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (cnt_clr) begin
      ovr_cnt_d  = '0;
      orph_cnt_d = '0;
    end else begin
      if (ovr_pulse)  ovr_cnt_d  = sat_inc(ovr_cnt_q);
      if (orph_pulse) orph_cnt_d = sat_inc(orph_cnt_q);
    end
  end

  always_ff @(posedge clk or posedge rst_clk) begin
    if (rst_clk) begin
      out_left_q  <= '0;
      out_right_q <= '0;
      out_valid_q <= 1'b0;
      pend_q      <= 1'b0;
      ack_q       <= 1'b0;
      ovr_cnt_q   <= '0;
      orph_cnt_q  <= '0;
    end else begin
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
      out_valid_q <= out_valid_d;
      pend_q      <= pend_d;
      ack_q       <= ack_d;
      ovr_cnt_q   <= ovr_cnt_d;
      orph_cnt_q  <= orph_cnt_d;
    end
  end

  assign out_left  = out_left_q;
  assign out_right = out_right_q;
  assign out_valid = out_valid_q;
  assign ovr_cnt   = ovr_cnt_q;
  assign orph_cnt  = orph_cnt_q;

endmodule

// File: tb/tb_i2s_rx_frame_sync.sv
// Self-checking bench for i2s_rx_frame_sync: table-driven pairing/orphan vectors plus
// hand-written latency, backpressure, saturation/clear, reset and randomised sequences.
// Ports: none.
`timescale 1ns/100ps
module tb_i2s_rx_frame_sync;

  localparam int SS     = 2;
  localparam int N_RAND = 150;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sck;
  logic [23:0] in_data;
  logic        in_lrn, in_en;
  logic [23:0] out_left, out_right;
  logic        out_valid, out_ready, cnt_clr;
  logic [7:0]  ovr_cnt, orph_cnt;

  int          checks = 0;
  int          failures = 0;
  int          sck_half = 163;
  int          valid_samples = 0;
  logic [47:0] got_q[$];
  logic        rand_done = 1'b0;

  i2s_rx_frame_sync #(.BITS_PRECISION(24), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .sck(sck),
    .in_data(in_data), .in_lrn(in_lrn), .in_en(in_en),
    .out_left(out_left), .out_right(out_right), .out_valid(out_valid), .out_ready(out_ready),
    .ovr_cnt(ovr_cnt), .orph_cnt(orph_cnt), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  // sck edges stay on half-ns instants so they never coincide with clk edges
  initial begin
    sck = 1'b0;
    #0.5;
    forever #(sck_half) sck = ~sck;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_word(input logic lrn, input logic [23:0] d, input int gap);
    @(negedge sck);
    in_data = d;
    in_lrn  = lrn;
    in_en   = 1'b1;
    @(negedge sck);
    in_en = 1'b0;
    repeat (gap) @(negedge sck);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #2 cnt_clr = 1'b1;
    @(posedge clk); #2 cnt_clr = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Output monitor: records accepted frames and checks stability under stall
  logic        stall_q = 1'b0;
  logic [47:0] stall_dat = '0;
  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", {out_left, out_right}, stall_dat);
      end
      if (out_valid) valid_samples++;
      if (out_valid && out_ready) got_q.push_back({out_left, out_right});
      stall_q   = out_valid && !out_ready;
      stall_dat = {out_left, out_right};
    end
  end

  typedef struct {
    logic        lrn;
    logic [23:0] dat;
    logic [7:0]  exp_orph;
    int          exp_frames;
    logic [47:0] exp_last;
  } vec_t;

  vec_t vt[10];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int bad;
    int last_idx;
    logic [23:0] l;
    logic [23:0] r;
    logic [15:0] idx;

    vt[0] = '{1'b1, 24'h111111, 8'd0, 0, 48'h0};
    vt[1] = '{1'b0, 24'h222222, 8'd0, 1, 48'h111111_222222};
    vt[2] = '{1'b0, 24'h333333, 8'd1, 1, 48'h111111_222222};
    vt[3] = '{1'b1, 24'h444444, 8'd1, 1, 48'h111111_222222};
    vt[4] = '{1'b1, 24'h555555, 8'd2, 1, 48'h111111_222222};
    vt[5] = '{1'b0, 24'h666666, 8'd2, 2, 48'h555555_666666};
    vt[6] = '{1'b1, 24'hFFFFFF, 8'd2, 2, 48'h555555_666666};
    vt[7] = '{1'b0, 24'h000000, 8'd2, 3, 48'hFFFFFF_000000};
    vt[8] = '{1'b0, 24'h5A5A5A, 8'd3, 3, 48'hFFFFFF_000000};
    vt[9] = '{1'b0, 24'hA5A5A5, 8'd4, 3, 48'hFFFFFF_000000};

    in_en = 1'b0; in_lrn = 1'b0; in_data = '0; out_ready = 1'b1; cnt_clr = 1'b0;
    #1 rst = 1'b1;
    settle(3);
    chk("rst_valid", out_valid, 0);
    chk("rst_left", out_left, 0);
    chk("rst_right", out_right, 0);
    chk("rst_ovr", ovr_cnt, 0);
    chk("rst_orph", orph_cnt, 0);
    rst = 1'b0;
    repeat (4) @(negedge sck);

    // Basic frame and latency from the sck edge that completes the pair
    send_word(1'b1, 24'h123456, 1);
    @(negedge sck);
    in_data = 24'hABCDEF; in_lrn = 1'b0; in_en = 1'b1;
    @(posedge sck);
    lat = 0;
    for (int n = 1; n <= 15; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    chk("latency", lat, SS + 1);
    chk("basic_left", out_left, 24'h123456);
    chk("basic_right", out_right, 24'hABCDEF);
    @(negedge sck);
    in_en = 1'b0;
    repeat (2) @(negedge sck);
    settle(5);
    chk("basic_frames", got_q.size(), 1);
    chk("basic_one_pulse", valid_samples, 1);

    // Table: pairing, overwrite and orphan handling
    got_q.delete();
    for (int i = 0; i < 10; i++) begin
      send_word(vt[i].lrn, vt[i].dat, 2);
      settle(10);
      chk($sformatf("vec%0d_orph", i), orph_cnt, vt[i].exp_orph);
      chk($sformatf("vec%0d_frames", i), got_q.size(), vt[i].exp_frames);
      if (vt[i].exp_frames > 0 && got_q.size() > 0)
        chk($sformatf("vec%0d_last", i), got_q[$], vt[i].exp_last);
    end

    // Backpressure: two frames buffered, third dropped
    got_q.delete();
    @(posedge clk); #2 out_ready = 1'b0;
    for (int f = 1; f <= 3; f++) begin
      send_word(1'b1, 24'h100000 + 24'(f), 2);
      send_word(1'b0, 24'h200000 + 24'(f), 2);
    end
    settle(10);
    chk("bp_ovr", ovr_cnt, 1);
    chk("bp_valid", out_valid, 1);
    chk("bp_left", out_left, 24'h100001);
    chk("bp_none_taken", got_q.size(), 0);
    @(posedge clk); #2 out_ready = 1'b1;
    settle(10);
    chk("bp_drained", out_valid, 0);
    chk("bp_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("bp_first", got_q[0], 48'h100001_200001);
      chk("bp_second", got_q[1], 48'h100002_200002);
    end

    // Saturation and clear priority
    pulse_clr();
    settle(2);
    chk("clr_ovr", ovr_cnt, 0);
    chk("clr_orph", orph_cnt, 0);
    @(negedge sck);
    in_lrn = 1'b0; in_en = 1'b1;
    repeat (300) begin
      @(negedge sck);
      in_data = in_data + 24'd1;
    end
    in_en = 1'b0;
    settle(10);
    chk("sat_orph", orph_cnt, 255);
    @(negedge sck);
    in_en = 1'b1;
    @(posedge sck);
    @(posedge clk); #2 cnt_clr = 1'b1;
    repeat (5) @(posedge clk);
    #2 cnt_clr = 1'b0;
    @(negedge sck);
    in_en = 1'b0;
    settle(10);
    chk("clr_wins", orph_cnt, 0);
    send_word(1'b0, 24'h0F0F0F, 1);
    settle(10);
    chk("count_after_clr", orph_cnt, 1);

    // Reset one clk after the pair completes
    got_q.delete();
    valid_samples = 0;
    send_word(1'b1, 24'h777777, 0);
    @(negedge sck);
    in_data = 24'h888888; in_lrn = 1'b0; in_en = 1'b1;
    @(posedge sck);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_left", out_left, 0);
    chk("mid_rst_right", out_right, 0);
    chk("mid_rst_ovr", ovr_cnt, 0);
    chk("mid_rst_orph", orph_cnt, 0);
    @(negedge sck);
    in_en = 1'b0;
    @(posedge clk); #2 rst = 1'b0;
    repeat (4) @(negedge sck);
    settle(10);
    chk("mid_rst_no_valid", valid_samples, 0);
    send_word(1'b0, 24'h999999, 2);
    settle(10);
    chk("post_rst_needs_left", got_q.size(), 0);
    chk("post_rst_orph", orph_cnt, 1);
    send_word(1'b1, 24'hAAAA01, 1);
    send_word(1'b0, 24'hBBBB01, 2);
    settle(10);
    chk("post_rst_frames", got_q.size(), 1);
    if (got_q.size() > 0) chk("post_rst_data", got_q[0], 48'hAAAA01_BBBB01);

    // Random ready and sck jitter against an ordered scoreboard
    pulse_clr();
    got_q.delete();
    fork
      begin
        for (int k = 0; k < N_RAND; k++) begin
          sck_half = 160 + int'($urandom_range(0, 6));
          send_word(1'b1, {8'hC3, 16'(k)}, int'($urandom_range(0, 2)));
          send_word(1'b0, {8'h3C, ~16'(k)}, int'($urandom_range(0, 2)));
        end
        rand_done = 1'b1;
      end
      begin
        int pct = 50;
        int cyc = 0;
        while (!rand_done) begin
          @(posedge clk); #2;
          out_ready = ($urandom_range(0, 99) < pct);
          cyc++;
          if (cyc % 256 == 0) pct = int'($urandom_range(2, 90));
        end
      end
    join
    @(posedge clk); #2 out_ready = 1'b1;
    sck_half = 163;
    repeat (4) @(negedge sck);
    settle(20);
    chk("rand_total", got_q.size() + int'(ovr_cnt), N_RAND);
    bad = 0;
    last_idx = -1;
    foreach (got_q[i]) begin
      l   = got_q[i][47:24];
      r   = got_q[i][23:0];
      idx = l[15:0];
      if (l[23:16] != 8'hC3 || r != {8'h3C, ~idx} || int'(idx) <= last_idx || int'(idx) >= N_RAND)
        bad++;
      last_idx = int'(idx);
    end
    chk("rand_integrity", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
